// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the processor memory stage and one
// peripheral requester; the CPU has priority, a starved peripheral forces a one-cycle stall.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int WAIT_W       = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wren,
  input  logic              cpu_access,
  output logic [DATA_W-1:0] cpu_q,
  output logic              cpu_stall,
  input  logic              per_req,
  input  logic              per_we,
  input  logic [DATA_W-1:0] per_addr,
  input  logic [DATA_W-1:0] per_wdata,
  output logic              per_gnt,
  output logic              per_done,
  output logic [DATA_W-1:0] per_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {IDLE, PEND, FORCE, DONE} state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wcnt, wcnt_nxt;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic              per_own;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      per_rdata <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (per_gnt) begin
        we_q    <= per_we;
        addr_q  <= per_addr;
        wdata_q <= per_wdata;
      end
      if (per_own)
        per_rdata <= mem_q;
    end
  end

  // The wait counter saturates at its last value; reaching it moves the request to FORCE.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    per_gnt   = 1'b0;
    per_done  = 1'b0;
    cpu_stall = 1'b0;
    per_own   = 1'b0;
    case (state)
      IDLE: begin
        per_gnt = per_req;
        if (per_req) begin
          state_nxt = PEND;
          wcnt_nxt  = '0;
        end
      end
      PEND: begin
        if (!cpu_access) begin
          per_own   = 1'b1;
          state_nxt = DONE;
        end else if (wcnt == WAIT_LAST) begin
          state_nxt = FORCE;
        end else begin
          wcnt_nxt = wcnt + WAIT_W'(1);
        end
      end
      FORCE: begin
        cpu_stall = 1'b1;
        per_own   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        per_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_addr = per_own ? addr_q  : cpu_addr;
  assign mem_data = per_own ? wdata_q : cpu_data;
  assign mem_wren = per_own ? we_q    : cpu_wren;
  assign cpu_q    = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a 256-word memory model, a per-cycle vector
// table, and hand-written sequences for starvation, back-to-back requests and reset.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_data, cpu_q;
  logic        cpu_wren, cpu_access, cpu_stall;
  logic        per_req, per_we, per_gnt, per_done;
  logic [31:0] per_addr, per_wdata, per_rdata;
  logic [31:0] mem_addr, mem_data, mem_q;
  logic        mem_wren;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:255];

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mem_wren) mem[mem_addr[7:0]] <= mem_data;

  assign mem_q = mem[mem_addr[7:0]];

  dmem_arbiter #(.DATA_W(32), .STARVE_LIMIT(4), .WAIT_W(3)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
    .cpu_access(cpu_access), .cpu_q(cpu_q), .cpu_stall(cpu_stall),
    .per_req(per_req), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
    .per_gnt(per_gnt), .per_done(per_done), .per_rdata(per_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  typedef struct {
    logic        acc, wren;
    logic [31:0] caddr, cdata;
    logic        preq, pwe;
    logic [31:0] paddr, pwdata;
    logic        gnt, done, stall, mwren;
    logic [31:0] maddr, mdata;
    logic        chk_q;
    logic [31:0] q;
    logic        chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [12];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic acc, input logic wren, input logic [31:0] caddr,
                                input logic [31:0] cdata, input logic preq, input logic pwe,
                                input logic [31:0] paddr, input logic [31:0] pwdata);
    cpu_access = acc;
    cpu_wren   = wren;
    cpu_addr   = caddr;
    cpu_data   = cdata;
    per_req    = preq;
    per_we     = pwe;
    per_addr   = paddr;
    per_wdata  = pwdata;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int done_seen;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];

    // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
    vecs = '{
      '{1'b1,1'b1,32'h10,32'hCAFE, 1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,1'b0,1'b1,32'h10,32'hCAFE, 1'b0,32'h0,   1'b0,32'h0},
      '{1'b1,1'b1,32'h40,32'hAB,   1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,1'b0,1'b1,32'h40,32'hAB,   1'b0,32'h0,   1'b0,32'h0},
      '{1'b1,1'b0,32'h40,32'h0,    1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,1'b0,1'b0,32'h40,32'h0,    1'b1,32'hAB,  1'b0,32'h0},
      '{1'b0,1'b0,32'h99,32'h0,    1'b1,1'b0,32'h10,32'h0,     1'b1,1'b0,1'b0,1'b0,32'h99,32'h0,    1'b0,32'h0,   1'b0,32'h0},
      '{1'b0,1'b0,32'h99,32'h0,    1'b0,1'b1,32'h77,32'hDEAD,  1'b0,1'b0,1'b0,1'b0,32'h10,32'h0,    1'b1,32'hCAFE,1'b0,32'h0},
      '{1'b0,1'b0,32'h99,32'h0,    1'b1,1'b1,32'h88,32'h1234,  1'b0,1'b1,1'b0,1'b0,32'h99,32'h0,    1'b0,32'h0,   1'b1,32'hCAFE},
      '{1'b1,1'b0,32'h40,32'h0,    1'b1,1'b1,32'h20,32'h55,    1'b1,1'b0,1'b0,1'b0,32'h40,32'h0,    1'b1,32'hAB,  1'b0,32'h0},
      '{1'b1,1'b0,32'h40,32'h0,    1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,1'b0,1'b0,32'h40,32'h0,    1'b1,32'hAB,  1'b0,32'h0},
      '{1'b1,1'b0,32'h40,32'h0,    1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,1'b0,1'b0,32'h40,32'h0,    1'b1,32'hAB,  1'b0,32'h0},
      '{1'b0,1'b0,32'h40,32'h0,    1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,1'b0,1'b1,32'h20,32'h55,   1'b0,32'h0,   1'b0,32'h0},
      '{1'b0,1'b0,32'h40,32'h0,    1'b0,1'b0,32'h0,32'h0,      1'b0,1'b1,1'b0,1'b0,32'h40,32'h0,    1'b1,32'hAB,  1'b0,32'h0},
      '{1'b1,1'b0,32'h20,32'h0,    1'b0,1'b0,32'h0,32'h0,      1'b0,1'b0,1'b0,1'b0,32'h20,32'h0,    1'b1,32'h55,  1'b0,32'h0}
    };

    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_output("reset_gnt",   32'(per_gnt),   32'h0);
    check_output("reset_done",  32'(per_done),  32'h0);
    check_output("reset_stall", 32'(cpu_stall), 32'h0);
    check_output("reset_rdata", per_rdata,      32'h0);
    next_cycle();
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].acc, vecs[i].wren, vecs[i].caddr, vecs[i].cdata,
                     vecs[i].preq, vecs[i].pwe, vecs[i].paddr, vecs[i].pwdata);
      @(negedge clock);
      check_output($sformatf("v%0d_gnt", i),   32'(per_gnt),   32'(vecs[i].gnt));
      check_output($sformatf("v%0d_done", i),  32'(per_done),  32'(vecs[i].done));
      check_output($sformatf("v%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].stall));
      check_output($sformatf("v%0d_wren", i),  32'(mem_wren),  32'(vecs[i].mwren));
      check_output($sformatf("v%0d_addr", i),  mem_addr,       vecs[i].maddr);
      check_output($sformatf("v%0d_data", i),  mem_data,       vecs[i].mdata);
      if (vecs[i].chk_q)  check_output($sformatf("v%0d_cpu_q", i), cpu_q, vecs[i].q);
      if (vecs[i].chk_rd) check_output($sformatf("v%0d_rdata", i), per_rdata, vecs[i].rd);
      next_cycle();
    end

    // Back-to-back reads with per_req held high: grant, access, done, repeat.
    b2b_addr[0] = 32'h10; b2b_data[0] = 32'hCAFE;
    b2b_addr[1] = 32'h40; b2b_data[1] = 32'hAB;
    b2b_addr[2] = 32'h20; b2b_data[2] = 32'h55;
    for (int k = 0; k < 9; k++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0,
                     (k % 3 == 0) ? b2b_addr[k/3] : 32'hFF, 32'h0);
      @(negedge clock);
      check_output($sformatf("b2b%0d_gnt", k),  32'(per_gnt),  (k % 3 == 0) ? 32'h1 : 32'h0);
      check_output($sformatf("b2b%0d_done", k), 32'(per_done), (k % 3 == 2) ? 32'h1 : 32'h0);
      if (k % 3 == 1) check_output($sformatf("b2b%0d_addr", k), mem_addr, b2b_addr[k/3]);
      if (k % 3 == 2) check_output($sformatf("b2b%0d_rdata", k), per_rdata, b2b_data[k/3]);
      next_cycle();
    end
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    // Starvation: CPU stores 1 to 0x30 every cycle while the peripheral wants to write 0x77 there.
    apply_stimulus(1'b1, 1'b1, 32'h30, 32'h1, 1'b1, 1'b1, 32'h30, 32'h77);
    @(negedge clock);
    check_output("starve_gnt", 32'(per_gnt), 32'h1);
    next_cycle();
    apply_stimulus(1'b1, 1'b1, 32'h30, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check_output($sformatf("pend%0d_stall", k), 32'(cpu_stall), 32'h0);
      check_output($sformatf("pend%0d_data", k),  mem_data,       32'h1);
      next_cycle();
    end
    @(negedge clock);
    check_output("force_stall", 32'(cpu_stall), 32'h1);
    check_output("force_addr",  mem_addr,       32'h30);
    check_output("force_data",  mem_data,       32'h77);
    check_output("force_wren",  32'(mem_wren),  32'h1);
    next_cycle();
    check_output("force_mem30", mem[8'h30], 32'h77);
    @(negedge clock);
    check_output("starve_done",  32'(per_done),  32'h1);
    check_output("starve_stall", 32'(cpu_stall), 32'h0);
    check_output("starve_cpu",   mem_data,       32'h1);
    next_cycle();

    // Reset two cycles into a contended PEND: the access is dropped without per_done.
    apply_stimulus(1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    next_cycle();
    apply_stimulus(1'b1, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    check_output("rst_stall", 32'(cpu_stall), 32'h0);
    check_output("rst_done",  32'(per_done),  32'h0);
    check_output("rst_rdata", per_rdata,      32'h0);
    check_output("rst_addr",  mem_addr,       32'h44);
    check_output("rst_wren",  32'(mem_wren),  32'h0);
    next_cycle();
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b1, 32'h50, 32'h9, 1'b0, 1'b0, 32'h0, 32'h0);
    done_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      if (per_done || cpu_stall) done_seen++;
      next_cycle();
    end
    check_output("rst_no_done", 32'(done_seen), 32'h0);
    @(negedge clock);
    check_output("rst_passthru_addr", mem_addr,      32'h50);
    check_output("rst_passthru_wren", 32'(mem_wren), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
